// File: rtl/mag_pkg.sv
// Shared definitions for the magnitude scheduler.
//   NUM_W / MAG_W : operand width and converter magnitude width
//   state_t       : scheduler FSM encoding (also exported as a debug port)
//   pick_winner   : round-robin choice between the two requesters
package mag_pkg;

  localparam int NUM_W = 8;
  localparam int MAG_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // A lone requester always wins. When both ask, the one that was not
  // served last wins. 'last' is the index of the last served requester.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    logic win;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/mag_sched_conv.sv
// Flag/magnitude converter shared by both requesters.
//   num   : operand to convert
//   light : flag bit (operand bit 0)
//   bin   : magnitude (operand bits 7:1)
module mag_sched_conv
  import mag_pkg::*;
(
  input  logic [NUM_W-1:0] num,
  output logic             light,
  output logic [MAG_W-1:0] bin
);

  assign light = num[0];
  assign bin   = num[NUM_W-1:1];

endmodule

// File: rtl/mag_sched.sv
// Two-requester round-robin scheduler in front of a shared converter.
// Each accepted request walks GRANT -> CAPTURE -> HOLD -> IDLE.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req[1:0]            : per-requester request
//   num0, num1          : requester operands
//   gnt[1:0]            : one-hot, one-cycle grant pulse
//   busy                : high whenever the FSM is not IDLE
//   conv_num            : latched operand driven to the converter
//   conv_light/conv_bin : converter response captured into light/bin
//   light, bin          : registered result
//   done                : one-cycle pulse, light/bin/done_id just updated
//   done_id             : requester whose result is on light/bin
//   state               : current FSM state (debug visibility)
//
// Handshake: a requester raises req[i] and keeps it high until it sees
// gnt[i]. req is only sampled in IDLE; it is ignored in every other state,
// and a request dropped before the IDLE sample edge is simply never served.
module mag_sched
  import mag_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [NUM_W-1:0] num0,
  input  logic [NUM_W-1:0] num1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [NUM_W-1:0] conv_num,
  input  logic             conv_light,
  input  logic [MAG_W-1:0] conv_bin,
  output logic             light,
  output logic [MAG_W-1:0] bin,
  output logic             done,
  output logic             done_id,
  output state_t           state
);

  // Counter loads HOLD_CYCLES-1 on entry to HOLD and leaves at zero, so
  // HOLD spans exactly HOLD_CYCLES cycles.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t           state_q, next_state;
  logic [3:0]       cnt_q;
  logic             win_q;
  logic             last_q;
  logic             win_next;
  logic [NUM_W-1:0] conv_num_q;
  logic             light_q;
  logic [MAG_W-1:0] bin_q;
  logic             done_id_q;

  // The internal converter sees the same operand as the external one; the
  // captured result comes from the conv_light/conv_bin ports so the
  // converter can be bypassed from outside.
  logic             unused_conv_light;
  logic [MAG_W-1:0] unused_conv_bin;

  mag_sched_conv u_conv (
    .num   (conv_num_q),
    .light (unused_conv_light),
    .bin   (unused_conv_bin)
  );

  assign win_next = pick_winner(req, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      win_q      <= 1'b0;
      last_q     <= 1'b1;  // requester 0 wins the first contested round
      conv_num_q <= '0;
      light_q    <= 1'b0;
      bin_q      <= '0;
      done_id_q  <= 1'b0;
    end else begin
      state_q <= next_state;
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_q      <= win_next;
            last_q     <= win_next;
            conv_num_q <= win_next ? num1 : num0;
          end
        end
        GRANT: begin
          // Converter output is valid during GRANT; it becomes visible
          // on light/bin in CAPTURE, aligned with the done pulse.
          light_q   <= conv_light;
          bin_q     <= conv_bin;
          done_id_q <= win_q;
        end
        CAPTURE: cnt_q <= HOLD_LOAD;
        HOLD: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state_q;
    gnt        = 2'b00;
    done       = 1'b0;
    case (state_q)
      IDLE:    if (|req) next_state = GRANT;
      GRANT: begin
        next_state = CAPTURE;
        gnt[win_q] = 1'b1;
      end
      CAPTURE: begin
        next_state = HOLD;
        done       = 1'b1;
      end
      HOLD:    if (cnt_q == 4'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign conv_num = conv_num_q;
  assign light    = light_q;
  assign bin      = bin_q;
  assign done_id  = done_id_q;
  assign state    = state_q;

endmodule
